// File: rtl/hififo_pkg.sv
// Shared definitions for the hififo PCIe DMA engines: TLP field constants,
// engine state encoding and TLP header assembly used by both directions.
package hififo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR0 = 2'd1,
        ST_HDR1 = 2'd2,
        ST_DATA = 2'd3
    } mwr_state_t;

    localparam logic [1:0] FMT_4DW_NODATA = 2'b01;
    localparam logic [1:0] FMT_4DW_DATA   = 2'b11;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;

    // First header beat: DW0 in the low half, DW1 (requester ID, tag, byte enables) in the high half.
    function automatic logic [63:0] tlp_hdr0(input logic [1:0]  fmt,
                                             input logic [4:0]  typ,
                                             input logic [15:0] req_id,
                                             input logic [7:0]  tag,
                                             input logic [9:0]  len);
        logic [31:0] dw0;
        logic [31:0] dw1;
        dw0 = {1'b0, fmt, typ, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, len};
        dw1 = {req_id, tag, 4'hF, 4'hF};
        return {dw1, dw0};
    endfunction

    // Second header beat of a 4DW header: address high DW first, then QW-aligned low DW.
    function automatic logic [63:0] tlp_hdr1(input logic [63:0] byte_addr);
        return {byte_addr[31:0] & 32'hFFFF_FFF8, byte_addr[63:32]};
    endfunction

endpackage

// File: rtl/hififo_tpc_mwr.sv
// To-PC DMA write engine: drains the tpc FIFO into fixed-size PCIe Memory Write
// TLPs (4DW header, 64-bit address) on the 64-bit AXI-stream TX port.
module hififo_tpc_mwr
    import hififo_pkg::*;
#(
    parameter int PAYLOAD_QW = 16,
    parameter int CW         = 10
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [15:0]   pci_id,
    input  logic          enable,
    input  logic [63:0]   addr,
    input  logic          addr_valid,
    output logic          addr_ready,
    input  logic [63:0]   fifo_data,
    input  logic [CW-1:0] fifo_count,
    output logic          fifo_read,
    output logic [63:0]   s_axis_tx_tdata,
    output logic          s_axis_tx_1dw,
    output logic          s_axis_tx_tlast,
    output logic          s_axis_tx_tvalid,
    input  logic          s_axis_tx_tready,
    output logic [31:0]   tlp_count
);

    localparam logic [9:0]    LEN_DW      = 10'(2 * PAYLOAD_QW);
    localparam logic [5:0]    LAST_BEAT   = 6'(PAYLOAD_QW - 1);
    localparam logic [CW-1:0] START_LEVEL = CW'(PAYLOAD_QW);
    localparam logic [63:0]   ADDR_MASK   = ~64'h0000_0000_0000_0007;

    mwr_state_t  state_r, state_s;
    logic [63:0] tdata_r, tdata_s;
    logic        tlast_r, tlast_s;
    logic        tvalid_r, tvalid_s;
    logic [63:0] addr_r, addr_s;
    logic [5:0]  beat_r, beat_s;
    logic        addr_ready_r, addr_ready_s;
    logic [31:0] count_r, count_s;
    logic        fifo_read_s;
    logic        load_hdr_s;
    logic        start_s;
    logic        accept_s;

    // Only start when a whole payload is already queued, so DATA can never underflow.
    assign start_s  = enable & addr_valid & (fifo_count >= START_LEVEL);
    assign accept_s = tvalid_r & s_axis_tx_tready;

    // Next-state and next-beat selection; a new beat loads on the edge the current one is accepted.
    always_comb begin
        state_s      = state_r;
        tdata_s      = tdata_r;
        tlast_s      = tlast_r;
        tvalid_s     = tvalid_r;
        addr_s       = addr_r;
        beat_s       = beat_r;
        count_s      = count_r;
        addr_ready_s = 1'b0;
        fifo_read_s  = 1'b0;
        load_hdr_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    load_hdr_s = 1'b1;
                end else begin
                    tvalid_s = 1'b0;
                    tlast_s  = 1'b0;
                end
            end
            ST_HDR0: begin
                if (accept_s) begin
                    tdata_s = tlp_hdr1(addr_r);
                    state_s = ST_HDR1;
                end else begin
                    state_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (accept_s) begin
                    tdata_s     = fifo_data;
                    fifo_read_s = 1'b1;
                    beat_s      = 6'd0;
                    tlast_s     = (LAST_BEAT == 6'd0);
                    state_s     = ST_DATA;
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    if (tlast_r) begin
                        count_s = count_r + 32'd1;
                        if (start_s) begin
                            load_hdr_s = 1'b1;
                        end else begin
                            tvalid_s = 1'b0;
                            tlast_s  = 1'b0;
                            state_s  = ST_IDLE;
                        end
                    end else begin
                        tdata_s     = fifo_data;
                        fifo_read_s = 1'b1;
                        beat_s      = beat_r + 6'd1;
                        tlast_s     = ((beat_r + 6'd1) == LAST_BEAT);
                    end
                end else begin
                    state_s = ST_DATA;
                end
            end
            default: begin
                state_s  = ST_IDLE;
                tvalid_s = 1'b0;
                tlast_s  = 1'b0;
            end
        endcase
        // Shared by the IDLE start and the back-to-back start off the last data beat.
        if (load_hdr_s) begin
            addr_s       = addr & ADDR_MASK;
            tdata_s      = tlp_hdr0(FMT_4DW_DATA, TYPE_MEM, pci_id, 8'h00, LEN_DW);
            tvalid_s     = 1'b1;
            tlast_s      = 1'b0;
            addr_ready_s = 1'b1;
            state_s      = ST_HDR0;
        end else begin
            addr_ready_s = 1'b0;
        end
    end

    // State, output beat and counters; reset abandons any packet in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            tdata_r      <= 64'h0;
            tlast_r      <= 1'b0;
            tvalid_r     <= 1'b0;
            addr_r       <= 64'h0;
            beat_r       <= 6'd0;
            addr_ready_r <= 1'b0;
            count_r      <= 32'd0;
        end else begin
            state_r      <= state_s;
            tdata_r      <= tdata_s;
            tlast_r      <= tlast_s;
            tvalid_r     <= tvalid_s;
            addr_r       <= addr_s;
            beat_r       <= beat_s;
            addr_ready_r <= addr_ready_s;
            count_r      <= count_s;
        end
    end

    // FWFT pop must coincide with the edge that captures the head word.
    assign fifo_read        = fifo_read_s;
    assign addr_ready       = addr_ready_r;
    assign s_axis_tx_tdata  = tdata_r;
    assign s_axis_tx_tlast  = tlast_r;
    assign s_axis_tx_tvalid = tvalid_r;
    assign s_axis_tx_1dw    = 1'b0;
    assign tlp_count        = count_r;

endmodule

// File: tb/tb_hififo_tpc_mwr.sv
// Scoreboard bench for hififo_tpc_mwr: FIFO and descriptor source models,
// expected beats queued at stimulus time and compared against captured beats.
module tb_hififo_tpc_mwr;

    localparam int PQ = 16;
    localparam int CW = 10;

    logic          clock = 1'b0;
    logic          reset;
    logic [15:0]   pci_id;
    logic          enable;
    logic [63:0]   addr;
    logic          addr_valid;
    logic          addr_ready;
    logic [63:0]   fifo_data;
    logic [CW-1:0] fifo_count;
    logic          fifo_read;
    logic [63:0]   tdata;
    logic          tx_1dw;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [31:0]   tlp_count;

    typedef struct packed {
        logic [31:0] cyc;
        logic        last;
        logic [63:0] data;
    } beat_t;

    beat_t       obs_q[$];
    beat_t       exp_q[$];
    logic [63:0] fifo_q[$];
    logic [63:0] desc_q[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_pops = 0;
    int   n_ardy = 0;
    int   stab_err = 0;
    int   exp_tlp = 0;
    bit   toggle_mode = 1'b0;
    logic prev_stall = 1'b0;
    logic [63:0] prev_data = 64'h0;
    logic prev_last = 1'b0;

    hififo_tpc_mwr #(.PAYLOAD_QW(PQ), .CW(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .pci_id           (pci_id),
        .enable           (enable),
        .addr             (addr),
        .addr_valid       (addr_valid),
        .addr_ready       (addr_ready),
        .fifo_data        (fifo_data),
        .fifo_count       (fifo_count),
        .fifo_read        (fifo_read),
        .s_axis_tx_tdata  (tdata),
        .s_axis_tx_1dw    (tx_1dw),
        .s_axis_tx_tlast  (tlast),
        .s_axis_tx_tvalid (tvalid),
        .s_axis_tx_tready (tready),
        .tlp_count        (tlp_count)
    );

    always #5 clock = ~clock;

    task automatic sync_inputs();
        if (fifo_q.size() > 0) fifo_data = fifo_q[0];
        else fifo_data = 64'h0;
        fifo_count = CW'(fifo_q.size());
        addr_valid = (desc_q.size() > 0);
        if (desc_q.size() > 0) addr = desc_q[0];
        else addr = 64'h0;
    endtask

    // One clock: sample at negedge, let the edge happen, then update the source models.
    task automatic step();
        beat_t b;
        logic pop_f;
        logic pop_d;
        @(negedge clock);
        if (tvalid === 1'b1 && tready === 1'b1) begin
            b.cyc = 32'(cyc); b.last = tlast; b.data = tdata;
            obs_q.push_back(b);
        end
        if (prev_stall === 1'b1 && tvalid === 1'b1 && (tdata !== prev_data || tlast !== prev_last))
            stab_err++;
        prev_stall = tvalid & ~tready;
        prev_data  = tdata;
        prev_last  = tlast;
        pop_f = fifo_read;
        pop_d = addr_ready;
        @(posedge clock);
        #1;
        cyc++;
        if (pop_f === 1'b1) begin
            n_pops++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (pop_d === 1'b1) begin
            n_ardy++;
            if (desc_q.size() > 0) void'(desc_q.pop_front());
        end
        if (toggle_mode) tready = ~tready;
        else tready = 1'b1;
        sync_inputs();
    endtask

    task automatic push_tlp(input logic [63:0] a, input logic [63:0] base);
        beat_t e;
        desc_q.push_back(a);
        e.cyc = 32'd0; e.last = 1'b0;
        e.data = {pci_id, 8'h00, 4'hF, 4'hF,
                  1'b0, 2'b11, 5'b00000, 1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 2'b00, 2'b00, 10'(2 * PQ)};
        exp_q.push_back(e);
        e.data = {a[31:3], 3'b000, a[63:32]};
        exp_q.push_back(e);
        for (int i = 0; i < PQ; i++) begin
            fifo_q.push_back(base + 64'(i));
            e.data = base + 64'(i);
            e.last = (i == PQ - 1);
            exp_q.push_back(e);
        end
        exp_tlp++;
        sync_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; tready = 1'b1; pci_id = 16'hDEAD;
        sync_inputs();
        repeat (3) @(posedge clock);
        #1;
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got %b exp 0", tvalid); end
        total++; if (tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast got %b exp 0", tlast); end
        total++; if (tdata !== 64'h0) begin bad++; $display("FAIL reset_tdata got %h exp 0", tdata); end
        total++; if (addr_ready !== 1'b0 || fifo_read !== 1'b0) begin bad++; $display("FAIL reset_handshake got ardy=%b rd=%b exp 0/0", addr_ready, fifo_read); end
        total++; if (tlp_count !== 32'd0 || tx_1dw !== 1'b0) begin bad++; $display("FAIL reset_count got %0d/1dw=%b exp 0/0", tlp_count, tx_1dw); end
        reset = 1'b0;
        enable = 1'b1;
        step();
    endtask

    task automatic test_single();
        int p0, a0;
        beat_t e, o;
        p0 = n_pops; a0 = n_ardy;
        push_tlp(64'h0000_0001_2345_6780, 64'd0);
        for (int k = 0; k < 60 && obs_q.size() < PQ + 2; k++) step();
        total++; if (obs_q.size() != PQ + 2) begin bad++; $display("FAIL single_beats got %0d exp %0d", obs_q.size(), PQ + 2); end
        if (obs_q.size() >= 2) begin
            total++; if (obs_q[0].data !== 64'hDEAD00FF_60000020) begin bad++; $display("FAIL single_hdr0 got %h exp DEAD00FF60000020", obs_q[0].data); end
            total++; if (obs_q[1].data !== 64'h23456780_00000001) begin bad++; $display("FAIL single_hdr1 got %h exp 2345678000000001", obs_q[1].data); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.data !== e.data || o.last !== e.last) begin bad++; $display("FAIL single_beat got %h/%b exp %h/%b", o.data, o.last, e.data, e.last); end
        end
        step();
        total++; if (tlp_count !== 32'(exp_tlp)) begin bad++; $display("FAIL single_tlp_count got %0d exp %0d", tlp_count, exp_tlp); end
        total++; if (n_pops - p0 != PQ || n_ardy - a0 != 1) begin bad++; $display("FAIL single_pops got %0d/%0d exp %0d/1", n_pops - p0, n_ardy - a0, PQ); end
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL single_idle got %b exp 0", tvalid); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_stall();
        int p0;
        beat_t e, o;
        p0 = n_pops; stab_err = 0;
        toggle_mode = 1'b1;
        push_tlp(64'h0000_0002_0000_1005, 64'd100);
        for (int k = 0; k < 120 && obs_q.size() < PQ + 2; k++) step();
        toggle_mode = 1'b0;
        total++; if (obs_q.size() != PQ + 2) begin bad++; $display("FAIL stall_beats got %0d exp %0d", obs_q.size(), PQ + 2); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.data !== e.data || o.last !== e.last) begin bad++; $display("FAIL stall_beat got %h/%b exp %h/%b", o.data, o.last, e.data, e.last); end
        end
        step();
        total++; if (stab_err != 0) begin bad++; $display("FAIL stall_stable got %0d changes exp 0", stab_err); end
        total++; if (n_pops - p0 != PQ) begin bad++; $display("FAIL stall_pops got %0d exp %0d", n_pops - p0, PQ); end
        total++; if (tlp_count !== 32'(exp_tlp)) begin bad++; $display("FAIL stall_tlp_count got %0d exp %0d", tlp_count, exp_tlp); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int a0;
        beat_t e, o;
        a0 = n_ardy;
        push_tlp(64'h0000_0003_0000_2000, 64'd200);
        push_tlp(64'h0000_0004_8000_0040, 64'd300);
        for (int k = 0; k < 100 && obs_q.size() < 2 * (PQ + 2); k++) step();
        total++; if (obs_q.size() != 2 * (PQ + 2)) begin bad++; $display("FAIL b2b_beats got %0d exp %0d", obs_q.size(), 2 * (PQ + 2)); end
        if (obs_q.size() == 2 * (PQ + 2)) begin
            total++;
            if (int'(obs_q[2 * PQ + 3].cyc) - int'(obs_q[0].cyc) != 2 * PQ + 3) begin
                bad++; $display("FAIL b2b_gap got span %0d exp %0d", int'(obs_q[2 * PQ + 3].cyc) - int'(obs_q[0].cyc), 2 * PQ + 3);
            end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.data !== e.data || o.last !== e.last) begin bad++; $display("FAIL b2b_beat got %h/%b exp %h/%b", o.data, o.last, e.data, e.last); end
        end
        step();
        total++; if (n_ardy - a0 != 2) begin bad++; $display("FAIL b2b_addr_ready got %0d exp 2", n_ardy - a0); end
        total++; if (tlp_count !== 32'(exp_tlp)) begin bad++; $display("FAIL b2b_tlp_count got %0d exp %0d", tlp_count, exp_tlp); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_fifo_threshold();
        int a0, push_cyc;
        logic [63:0] held;
        beat_t e, o;
        a0 = n_ardy;
        push_tlp(64'h0000_0005_0000_3000, 64'd400);
        held = fifo_q.pop_back();
        sync_inputs();
        repeat (100) step();
        total++; if (obs_q.size() != 0 || n_ardy != a0) begin bad++; $display("FAIL thresh_early got beats=%0d ardy=%0d exp 0/0", obs_q.size(), n_ardy - a0); end
        fifo_q.push_back(held);
        sync_inputs();
        push_cyc = cyc;
        for (int k = 0; k < 60 && obs_q.size() < PQ + 2; k++) step();
        total++; if (obs_q.size() != PQ + 2) begin bad++; $display("FAIL thresh_beats got %0d exp %0d", obs_q.size(), PQ + 2); end
        if (obs_q.size() > 0) begin
            total++; if (int'(obs_q[0].cyc) - push_cyc != 1) begin bad++; $display("FAIL thresh_latency got %0d exp 1", int'(obs_q[0].cyc) - push_cyc); end
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.data !== e.data || o.last !== e.last) begin bad++; $display("FAIL thresh_beat got %h/%b exp %h/%b", o.data, o.last, e.data, e.last); end
        end
        step();
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_disable_midway();
        int a0;
        beat_t e, o;
        a0 = n_ardy;
        push_tlp(64'h0000_0006_0000_4000, 64'd500);
        desc_q.push_back(64'h0000_0007_0000_5000);
        for (int i = 0; i < 64; i++) fifo_q.push_back(64'hF000 + 64'(i));
        sync_inputs();
        for (int k = 0; k < 20 && obs_q.size() < 3; k++) step();
        enable = 1'b0;
        repeat (60) step();
        total++; if (obs_q.size() != PQ + 2) begin bad++; $display("FAIL dis_beats got %0d exp %0d", obs_q.size(), PQ + 2); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.data !== e.data || o.last !== e.last) begin bad++; $display("FAIL dis_beat got %h/%b exp %h/%b", o.data, o.last, e.data, e.last); end
        end
        total++; if (tvalid !== 1'b0 || n_ardy - a0 != 1) begin bad++; $display("FAIL dis_no_restart got tvalid=%b ardy=%0d exp 0/1", tvalid, n_ardy - a0); end
        total++; if (tlp_count !== 32'(exp_tlp)) begin bad++; $display("FAIL dis_tlp_count got %0d exp %0d", tlp_count, exp_tlp); end
        desc_q.delete(); fifo_q.delete(); exp_q.delete(); obs_q.delete();
        sync_inputs();
        enable = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        beat_t e, o;
        push_tlp(64'h0000_0008_0000_6000, 64'd600);
        for (int k = 0; k < 30 && obs_q.size() < 7; k++) step();
        reset = 1'b1;
        #1;
        total++; if (tvalid !== 1'b0) begin bad++; $display("FAIL rst_mid_tvalid got %b exp 0", tvalid); end
        total++; if (tlp_count !== 32'd0 || fifo_read !== 1'b0) begin bad++; $display("FAIL rst_mid_state got count=%0d rd=%b exp 0/0", tlp_count, fifo_read); end
        desc_q.delete(); fifo_q.delete(); exp_q.delete(); obs_q.delete();
        exp_tlp = 0;
        sync_inputs();
        repeat (2) step();
        reset = 1'b0;
        push_tlp(64'h0000_0009_0000_7000, 64'd700);
        for (int k = 0; k < 60 && obs_q.size() < PQ + 2; k++) step();
        total++; if (obs_q.size() != PQ + 2) begin bad++; $display("FAIL rst_mid_beats got %0d exp %0d", obs_q.size(), PQ + 2); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            total++;
            if (o.data !== e.data || o.last !== e.last) begin bad++; $display("FAIL rst_mid_beat got %h/%b exp %h/%b", o.data, o.last, e.data, e.last); end
        end
        step();
        total++; if (tlp_count !== 32'(exp_tlp)) begin bad++; $display("FAIL rst_mid_tlp_count got %0d exp %0d", tlp_count, exp_tlp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_fifo_threshold();
        test_disable_midway();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
